// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with operand forwarding and
//               load-use hazard detection, feeding the EX-stage ALU.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_*                            decoded fields from ID (captured each edge)
//   flush                           branch taken: replace ID instruction with bubble
//   exmem_*, memwb_*                live forwarding sources
//   ALU_src_1/2, ALU_control, shamt ALU drive (operands combinational)
//   ex_store_data                   forwarded rt for stores
//   ex_dest_reg, ex_valid, ex_*     registered EX control
//   stall_id                        hold PC and IF/ID this cycle
//
// Optional: `define ID_EX_HAZARD_STATS_EN adds stall_count / flush_count.
// ----------------------------------------------------------------------------

// Per-source forwarding mux: EX/MEM beats MEM/WB beats register-file data.
// Register 0 is never forwarded.
module id_ex_fwd #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_idx,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_alu_out,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_wdata,
    output logic [DATA_W-1:0]     fwd_data
);
    always_comb begin
        fwd_data = reg_data;
        if (src_idx != '0) begin
            if (exmem_reg_write && exmem_rd == src_idx)
                fwd_data = exmem_alu_out;
            else if (memwb_reg_write && memwb_rd == src_idx)
                fwd_data = memwb_wdata;
        end
    end
endmodule

module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [4:0]            id_shamt,
    input  logic [2:0]            id_alu_control,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_alu_out,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_wdata,
    output logic [DATA_W-1:0]     ALU_src_1,
    output logic [DATA_W-1:0]     ALU_src_2,
    output logic [2:0]            ALU_control,
    output logic [4:0]            shamt,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dest_reg,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  stall_id
`ifdef ID_EX_HAZARD_STATS_EN
   ,output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);
    localparam int NUM_SRC = 2;  // rs, rt

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic [2:0]            alu_control;
        logic [4:0]            shamt;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
    } ex_t;

    ex_t ex_q, ex_d;

    // Load in EX whose destination is read by the instruction in ID.
    // A flush kills the ID instruction, so there is nothing to stall for.
    assign stall_id = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.dest != '0) &
                      ((ex_q.dest == id_rs) | (ex_q.dest == id_rt)) & ~flush;

    always_comb begin
        ex_d             = '0;
        ex_d.valid       = id_valid;
        ex_d.reg_write   = id_reg_write;
        ex_d.mem_read    = id_mem_read;
        ex_d.mem_write   = id_mem_write;
        ex_d.mem_to_reg  = id_mem_to_reg;
        ex_d.alu_src     = id_alu_src;
        ex_d.alu_control = id_alu_control;
        ex_d.shamt       = id_shamt;
        ex_d.dest        = id_reg_dst ? id_rd : id_rt;
        ex_d.rs          = id_rs;
        ex_d.rt          = id_rt;
        ex_d.rs_data     = id_rs_data;
        ex_d.rt_data     = id_rt_data;
        ex_d.imm         = id_imm;
        // Bubble: data fields still load, but nothing downstream commits.
        if (flush || stall_id) begin
            ex_d.valid       = 1'b0;
            ex_d.reg_write   = 1'b0;
            ex_d.mem_read    = 1'b0;
            ex_d.mem_write   = 1'b0;
            ex_d.mem_to_reg  = 1'b0;
            ex_d.alu_control = '0;
            ex_d.dest        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_idx;
    logic [NUM_SRC-1:0][DATA_W-1:0]     src_data;
    logic [NUM_SRC-1:0][DATA_W-1:0]     fwd_data;

    assign src_idx  = {ex_q.rt, ex_q.rs};
    assign src_data = {ex_q.rt_data, ex_q.rs_data};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
        id_ex_fwd #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd (
            .src_idx         (src_idx[s]),
            .reg_data        (src_data[s]),
            .exmem_reg_write (exmem_reg_write),
            .exmem_rd        (exmem_rd),
            .exmem_alu_out   (exmem_alu_out),
            .memwb_reg_write (memwb_reg_write),
            .memwb_rd        (memwb_rd),
            .memwb_wdata     (memwb_wdata),
            .fwd_data        (fwd_data[s])
        );
    end

    // Shift ops take their shifted operand from rt.
    assign ALU_src_1     = (ex_q.alu_control == 3'b111 || ex_q.alu_control == 3'b011)
                           ? fwd_data[1] : fwd_data[0];
    assign ALU_src_2     = ex_q.alu_src ? ex_q.imm : fwd_data[1];
    assign ex_store_data = fwd_data[1];
    assign ALU_control   = ex_q.alu_control;
    assign shamt         = ex_q.shamt;
    assign ex_dest_reg   = ex_q.dest;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;

`ifdef ID_EX_HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_id) stall_count <= stall_count + 32'd1;
            if (flush)    flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, ALU operand capture, forwarding
// priority, load-use stall, flush priority, shifts and immediates.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [2:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_alu_out, memwb_wdata;
    logic [31:0] ALU_src_1, ALU_src_2, ex_store_data;
    logic [2:0]  ALU_control;
    logic [4:0]  shamt, ex_dest_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall_id;
`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .ALU_src_1(ALU_src_1), .ALU_src_2(ALU_src_2), .ALU_control(ALU_control), .shamt(shamt),
        .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .stall_id(stall_id)
`ifdef ID_EX_HAZARD_STATS_EN
       ,.stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_alu_control = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic fwd_clear();
        exmem_reg_write = 0; exmem_rd = 0; exmem_alu_out = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
    endtask

    // lw $4, 8($1)
    task automatic id_lw4();
        id_clear();
        id_valid = 1; id_rs = 1; id_rt = 4; id_imm = 8; id_alu_src = 1;
        id_alu_control = 3'b010; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    endtask

    // add $5, $4, $1
    task automatic id_add_use4();
        id_clear();
        id_valid = 1; id_rs = 4; id_rt = 1; id_rd = 5; id_reg_dst = 1;
        id_alu_control = 3'b010; id_reg_write = 1;
    endtask

    initial begin
        rst_n = 0; flush = 0;
        id_clear(); fwd_clear();
        #1;
        chk("reset_ex_valid", {31'd0, ex_valid}, 0);
        chk("reset_src1", ALU_src_1, 0);
        chk("reset_dest", {27'd0, ex_dest_reg}, 0);
        step();
        rst_n = 1;

        // add $3,$1,$2
        id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_reg_dst = 1;
        id_rs_data = 10; id_rt_data = 20; id_alu_control = 3'b010; id_reg_write = 1;
        step();
        chk("add_src1", ALU_src_1, 10);
        chk("add_src2", ALU_src_2, 20);
        chk("add_dest", {27'd0, ex_dest_reg}, 3);
        chk("add_valid", {31'd0, ex_valid}, 1);
        chk("add_ctl", {29'd0, ALU_control}, 3'b010);

        // Forwarding priority on rs = 5, rt = 6
        id_rs = 5; id_rs_data = 32'h1111; id_rt = 6; id_rt_data = 32'h66;
        step();
        exmem_reg_write = 1; exmem_rd = 5; exmem_alu_out = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd = 5; memwb_wdata = 32'hBBBB;
        #1;
        chk("fwd_exmem", ALU_src_1, 32'hAAAA);
        chk("fwd_store_nomatch", ex_store_data, 32'h66);
        exmem_reg_write = 0;
        #1;
        chk("fwd_memwb", ALU_src_1, 32'hBBBB);
        memwb_rd = 6;
        #1;
        chk("fwd_rt_memwb", ALU_src_2, 32'hBBBB);

        // rs = 0 is never forwarded
        id_rs = 0; id_rs_data = 32'h1234;
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        step();
        chk("fwd_r0", ALU_src_1, 32'h1234);
        fwd_clear();

        // Load-use: lw $4 in EX, add using $4 in ID
        id_lw4();
        step();
        chk("lw_memread", {31'd0, ex_mem_read}, 1);
        id_add_use4();
        #1;
        chk("lu_stall", {31'd0, stall_id}, 1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 0);
        chk("lu_bubble_wr", {31'd0, ex_reg_write}, 0);
        chk("lu_bubble_dest", {27'd0, ex_dest_reg}, 0);
        chk("lu_stall_once", {31'd0, stall_id}, 0);
        step();
        chk("lu_add_valid", {31'd0, ex_valid}, 1);
        chk("lu_add_dest", {27'd0, ex_dest_reg}, 5);

        // Flush with a simultaneous load-use hazard
        id_lw4();
        step();
        id_add_use4();
        flush = 1;
        #1;
        chk("fl_stall_forced0", {31'd0, stall_id}, 0);
        step();
        flush = 0;
        chk("fl_bubble_valid", {31'd0, ex_valid}, 0);
        chk("fl_bubble_memread", {31'd0, ex_mem_read}, 0);
        chk("fl_bubble_wr", {31'd0, ex_reg_write}, 0);
`ifdef ID_EX_HAZARD_STATS_EN
        chk("flush_count", flush_count, 1);
        chk("stall_count", stall_count, 1);  // the one earlier load-use stall
`endif

        // sll $2,$7,4
        id_clear();
        id_valid = 1; id_rt = 7; id_rt_data = 32'h1; id_rd = 2; id_reg_dst = 1;
        id_alu_control = 3'b111; id_shamt = 4; id_reg_write = 1;
        step();
        chk("sll_src1", ALU_src_1, 32'h1);
        chk("sll_shamt", {27'd0, shamt}, 4);
        chk("sll_dest", {27'd0, ex_dest_reg}, 2);

        // addi with negative immediate
        id_clear();
        id_valid = 1; id_rs = 1; id_rs_data = 3; id_rt = 9; id_rt_data = 32'h99;
        id_imm = 32'hFFFF_FFF0; id_alu_src = 1; id_alu_control = 3'b010; id_reg_write = 1;
        step();
        chk("imm_src1", ALU_src_1, 3);
        chk("imm_src2", ALU_src_2, 32'hFFFF_FFF0);
        chk("imm_dest_rt", {27'd0, ex_dest_reg}, 9);

        // Asynchronous reset in the middle of a stall
        id_lw4();
        step();
        id_add_use4();
        #1;
        chk("pre_rst_stall", {31'd0, stall_id}, 1);
        #1;
        rst_n = 0;
        #1;
        chk("rst_stall", {31'd0, stall_id}, 0);
        chk("rst_valid", {31'd0, ex_valid}, 0);
        chk("rst_memread", {31'd0, ex_mem_read}, 0);
        chk("rst_src2", ALU_src_2, 0);
        chk("rst_dest", {27'd0, ex_dest_reg}, 0);
`ifdef ID_EX_HAZARD_STATS_EN
        chk("rst_stall_count", stall_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
